mos_gate_evaluator: RTL and testbench
=====================================

Name: mos_gate_evaluator

Overview:
- Clocked, synthesizable four-valued model of a static CMOS gate built from NMOS/PMOS switches.
- Each input drives one PMOS in the pull-up network and one NMOS in the pull-down network.
- Topology select gives NAND style (PMOS parallel, NMOS series) or NOR style (PMOS series, NMOS parallel).
- The resolved output node value is registered. Used as a cell-level reference model for transistor-level gates such as nand2.

Parameters:
- N, 2, number of gate inputs (legal range 1..8).
- LAT, 1, output pipeline depth in clock cycles (legal range 1..4).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable; when 0, no new evaluation enters the pipeline.
- topo  input  1  0 = NAND topology, 1 = NOR topology.
- g  input  2*N  four-valued gate inputs; input i occupies bits [2i+1:2i].
- out  output  2  resolved output node value, four-valued.
- out_valid  output  1  out holds a result produced from an enabled sample.
- contention  output  1  pull-up and pull-down networks both definitely on.
- floating  output  1  both networks definitely off.

Behaviour:
- Encoding, used for every 2-bit value: 2'b00 = 0, 2'b01 = 1, 2'b10 = Z, 2'b11 = X.
- Device conduction is one of ON, OFF or UNK:
  - NMOS: gate 1 -> ON, gate 0 -> OFF, gate Z/X -> UNK.
  - PMOS: gate 0 -> ON, gate 1 -> OFF, gate Z/X -> UNK.
- Series network: OFF if any device is OFF; else ON if all devices are ON; else UNK.
- Parallel network: ON if any device is ON; else OFF if all devices are OFF; else UNK.
- N=1: both networks reduce to the single device, so topo has no effect.
- Resolution, with pu = pull-up network state and pd = pull-down network state:
  - pu ON, pd OFF -> 1.
  - pu OFF, pd ON -> 0.
  - pu OFF, pd OFF -> Z; floating = 1.
  - pu ON, pd ON -> X; contention = 1.
  - Any network UNK -> X; contention = 0 and floating = 0.
- Timing:
  - Evaluation is combinational from g/topo sampled at a rising edge with en = 1.
  - The result appears on out/contention/floating/out_valid exactly LAT cycles after the sampling edge.
  - Stages are registered and shift every cycle.
  - A cycle with en = 0 inserts a bubble: that stage's out_valid = 0, and out/flags hold their previous values when the bubble reaches the output.
- Reset: synchronous, takes priority over en. At the edge where rst = 1, all pipeline stages clear:
  - out = 2'b10 (Z)
  - out_valid = 0
  - contention = 0
  - floating = 0
- Reset asserted mid-pipeline discards all in-flight results. The first valid result reappears LAT cycles after the first enabled sample following deassertion.
- Inputs with undefined simulator values (x/z on the wires themselves) are outside contract.
- No other state exists; there is no internal hold of the node value beyond the pipeline.

Test Plan:
- NAND2 truth table, N=2, topo=0, LAT=1, en=1: apply g[A,B] = 00, 01, 10, 11 in successive cycles -> out = 1, 1, 1, 0 one cycle later each; out_valid = 1; flags 0.
- NOR2 truth table, topo=1: g = 00, 01, 10, 11 -> out = 1, 0, 0, 0.
- Unknown handling, NAND2:
  - A = X, B = 0 -> out = 1 (parallel PMOS ON via B, series NMOS OFF).
  - A = X, B = 1 -> out = X, flags 0.
  - A = Z, B = Z -> out = X.
- Latency and bubbles, LAT=3: enable for 2 cycles, drop en for 1, enable again -> out_valid pattern 0, 0, 0, 1, 1, 0, 1 from the first sample edge; out holds during the bubble.
- Reset: drive valid inputs, assert rst for 1 cycle with LAT=2 mid-stream -> next edge out = Z, out_valid = 0; the first post-reset valid result appears 2 cycles after the first enabled sample.
- Contention/float, N=1: g = 1 -> out = 0; g = 0 -> out = 1. Then force pu ON/pd ON using N=2, topo=1 is impossible, so check that contention never asserts for any legal g in exhaustive 16-combination sweeps of N=2, both topologies.

Source files
------------

// File: rtl/mos_gate_evaluator.sv
// Four-valued static CMOS gate model: NAND/NOR switch networks resolved to a node
// value, carried through a LAT-deep registered pipeline with bubble-hold at the output.
module mos_gate_evaluator #(
  parameter int unsigned N   = 2,
  parameter int unsigned LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           topo,
  input  logic [2*N-1:0] g,
  output logic [1:0]     out,
  output logic           out_valid,
  output logic           contention,
  output logic           floating
);

  localparam logic [1:0] V0 = 2'b00;
  localparam logic [1:0] V1 = 2'b01;
  localparam logic [1:0] VZ = 2'b10;
  localparam logic [1:0] VX = 2'b11;

  typedef struct packed {
    logic       v;
    logic [1:0] val;
    logic       cont;
    logic       flt;
  } stage_t;

  localparam stage_t STAGE_RST = '{v: 1'b0, val: VZ, cont: 1'b0, flt: 1'b0};

  logic any_n_on, all_n_on, any_n_off, all_n_off;
  logic any_p_on, all_p_on, any_p_off, all_p_off;
  logic pu_on, pu_off, pd_on, pd_off;
  stage_t eval_c;
  stage_t st_in [LAT];
  stage_t st_q  [LAT];

  // Per-device conduction summaries; Z/X gates count as neither on nor off.
  always_comb begin
    any_n_on  = 1'b0;
    all_n_on  = 1'b1;
    any_n_off = 1'b0;
    all_n_off = 1'b1;
    any_p_on  = 1'b0;
    all_p_on  = 1'b1;
    any_p_off = 1'b0;
    all_p_off = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      any_n_on  = any_n_on  | (g[2*i +: 2] == V1);
      all_n_on  = all_n_on  & (g[2*i +: 2] == V1);
      any_n_off = any_n_off | (g[2*i +: 2] == V0);
      all_n_off = all_n_off & (g[2*i +: 2] == V0);
      any_p_on  = any_p_on  | (g[2*i +: 2] == V0);
      all_p_on  = all_p_on  & (g[2*i +: 2] == V0);
      any_p_off = any_p_off | (g[2*i +: 2] == V1);
      all_p_off = all_p_off & (g[2*i +: 2] == V1);
    end
  end

  // NAND: PMOS parallel / NMOS series; NOR: PMOS series / NMOS parallel.
  always_comb begin
    pu_on  = topo ? all_p_on  : any_p_on;
    pu_off = topo ? any_p_off : all_p_off;
    pd_on  = topo ? any_n_on  : all_n_on;
    pd_off = topo ? all_n_off : any_n_off;
  end

  // Node resolution; any UNK network gives X with both flags clear.
  always_comb begin
    eval_c = '{v: en, val: VX, cont: 1'b0, flt: 1'b0};
    if (pu_on && pd_off) begin
      eval_c.val = V1;
    end else if (pu_off && pd_on) begin
      eval_c.val = V0;
    end else if (pu_off && pd_off) begin
      eval_c.val = VZ;
      eval_c.flt = 1'b1;
    end else if (pu_on && pd_on) begin
      eval_c.val  = VX;
      eval_c.cont = 1'b1;
    end
  end

  always_comb begin
    st_in[0] = eval_c;
    for (int unsigned i = 1; i < LAT; i++) begin
      st_in[i] = st_q[i-1];
    end
  end

  // Valid shifts every cycle; payload only advances with a valid token so bubbles hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        st_q[i] <= STAGE_RST;
      end
    end else begin
      for (int unsigned i = 0; i < LAT; i++) begin
        st_q[i].v <= st_in[i].v;
        if (st_in[i].v) begin
          st_q[i].val  <= st_in[i].val;
          st_q[i].cont <= st_in[i].cont;
          st_q[i].flt  <= st_in[i].flt;
        end
      end
    end
  end

  assign out        = st_q[LAT-1].val;
  assign out_valid  = st_q[LAT-1].v;
  assign contention = st_q[LAT-1].cont;
  assign floating   = st_q[LAT-1].flt;

endmodule

// File: tb/tb_mos_gate_evaluator.sv
// Directed bench for mos_gate_evaluator: truth tables, unknowns, latency/bubbles,
// mid-stream reset and N=1 behaviour across four parameterisations.
module tb_mos_gate_evaluator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // a: N=2 LAT=1, b: N=2 LAT=3, c: N=2 LAT=2, d: N=1 LAT=1
  logic rst_a, en_a, topo_a, val_a, cont_a, flt_a;
  logic rst_b, en_b, topo_b, val_b, cont_b, flt_b;
  logic rst_c, en_c, topo_c, val_c, cont_c, flt_c;
  logic rst_d, en_d, topo_d, val_d, cont_d, flt_d;
  logic [3:0] g_a, g_b, g_c;
  logic [1:0] g_d;
  logic [1:0] out_a, out_b, out_c, out_d;

  mos_gate_evaluator #(.N(2), .LAT(1)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .topo(topo_a), .g(g_a),
    .out(out_a), .out_valid(val_a), .contention(cont_a), .floating(flt_a));
  mos_gate_evaluator #(.N(2), .LAT(3)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .topo(topo_b), .g(g_b),
    .out(out_b), .out_valid(val_b), .contention(cont_b), .floating(flt_b));
  mos_gate_evaluator #(.N(2), .LAT(2)) dut_c (
    .clk(clk), .rst(rst_c), .en(en_c), .topo(topo_c), .g(g_c),
    .out(out_c), .out_valid(val_c), .contention(cont_c), .floating(flt_c));
  mos_gate_evaluator #(.N(1), .LAT(1)) dut_d (
    .clk(clk), .rst(rst_d), .en(en_d), .topo(topo_d), .g(g_d),
    .out(out_d), .out_valid(val_d), .contention(cont_d), .floating(flt_d));

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] nand_exp [4];
  logic [1:0] nor_exp  [4];
  logic [1:0] ab;

  initial begin
    nand_exp = '{2'b01, 2'b01, 2'b01, 2'b00};
    nor_exp  = '{2'b01, 2'b00, 2'b00, 2'b00};
    {rst_a, rst_b, rst_c, rst_d} = 4'hF;
    {en_a, en_b, en_c, en_d}     = 4'h0;
    {topo_a, topo_b, topo_c, topo_d} = 4'h0;
    g_a = '0; g_b = '0; g_c = '0; g_d = '0;
    step();
    step();
    chk("rst_out_a", 8'(out_a), 8'h02);
    chk("rst_val_a", 8'(val_a), 8'h00);
    chk("rst_flags_a", 8'({cont_a, flt_a}), 8'h00);
    chk("rst_out_b", 8'(out_b), 8'h02);
    chk("rst_val_c", 8'(val_c), 8'h00);
    chk("rst_out_d", 8'(out_d), 8'h02);
    {rst_a, rst_b, rst_c, rst_d} = 4'h0;

    // NAND2 / NOR2 truth tables, A = input 0, B = input 1
    en_a = 1'b1;
    for (int t = 0; t < 2; t++) begin
      topo_a = 1'(t);
      for (int k = 0; k < 4; k++) begin
        ab  = 2'(k);
        g_a = {1'b0, ab[0], 1'b0, ab[1]};
        step();
        chk(t == 0 ? "nand_out" : "nor_out", 8'(out_a), 8'(t == 0 ? nand_exp[k] : nor_exp[k]));
        chk("tt_val", 8'(val_a), 8'h01);
        chk("tt_flags", 8'({cont_a, flt_a}), 8'h00);
      end
    end

    // Unknown gate values on NAND2
    topo_a = 1'b0;
    g_a = {2'b00, 2'b11};
    step();
    chk("nand_x0", 8'(out_a), 8'h01);
    g_a = {2'b01, 2'b11};
    step();
    chk("nand_x1", 8'(out_a), 8'h03);
    chk("nand_x1_flags", 8'({cont_a, flt_a}), 8'h00);
    g_a = {2'b10, 2'b10};
    step();
    chk("nand_zz", 8'(out_a), 8'h03);

    // Exhaustive four-valued sweeps: neither flag can assert for N=2
    for (int t = 0; t < 2; t++) begin
      topo_a = 1'(t);
      for (int k = 0; k < 16; k++) begin
        g_a = 4'(k);
        step();
        chk("sweep_cont", 8'(cont_a), 8'h00);
        chk("sweep_flt", 8'(flt_a), 8'h00);
      end
    end
    en_a = 1'b0;

    // N=1 inverter; topo is irrelevant
    en_d = 1'b1;
    g_d = 2'b01;
    step();
    chk("inv_1", 8'(out_d), 8'h00);
    g_d = 2'b00;
    step();
    chk("inv_0", 8'(out_d), 8'h01);
    topo_d = 1'b1;
    g_d = 2'b01;
    step();
    chk("inv_1_nor", 8'(out_d), 8'h00);
    g_d = 2'b10;
    step();
    chk("inv_z", 8'(out_d), 8'h03);
    chk("inv_z_flags", 8'({cont_d, flt_d}), 8'h00);
    en_d = 1'b0;

    // LAT=3 with one bubble: valid 0,0,0,1,1,0,1 from the first sample cycle
    chk("lat_v0", 8'(val_b), 8'h00);
    en_b = 1'b1; g_b = 4'b0000;
    step();
    chk("lat_v1", 8'(val_b), 8'h00);
    g_b = 4'b0101;
    step();
    chk("lat_v2", 8'(val_b), 8'h00);
    en_b = 1'b0; g_b = 4'b0000;
    step();
    chk("lat_v3", 8'(val_b), 8'h01);
    chk("lat_o3", 8'(out_b), 8'h01);
    en_b = 1'b1; g_b = 4'b0000;
    step();
    chk("lat_v4", 8'(val_b), 8'h01);
    chk("lat_o4", 8'(out_b), 8'h00);
    en_b = 1'b0;
    step();
    chk("lat_v5", 8'(val_b), 8'h00);
    chk("lat_hold", 8'(out_b), 8'h00);
    step();
    chk("lat_v6", 8'(val_b), 8'h01);
    chk("lat_o6", 8'(out_b), 8'h01);

    // LAT=2 reset mid-stream
    en_c = 1'b1; g_c = 4'b0101;
    step();
    g_c = 4'b0000;
    step();
    chk("rs_pre_out", 8'(out_c), 8'h00);
    chk("rs_pre_val", 8'(val_c), 8'h01);
    step();
    rst_c = 1'b1;
    step();
    chk("rs_out", 8'(out_c), 8'h02);
    chk("rs_val", 8'(val_c), 8'h00);
    chk("rs_flags", 8'({cont_c, flt_c}), 8'h00);
    rst_c = 1'b0; en_c = 1'b0;
    step();
    chk("rs_drain_val", 8'(val_c), 8'h00);
    chk("rs_drain_out", 8'(out_c), 8'h02);
    en_c = 1'b1; g_c = 4'b0101;
    step();
    chk("rs_first_val0", 8'(val_c), 8'h00);
    en_c = 1'b0;
    step();
    chk("rs_first_val", 8'(val_c), 8'h01);
    chk("rs_first_out", 8'(out_c), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
